seq_divider: RTL and testbench



---
 rtl/alu_pkg.sv | 21 ++
 rtl/div_step.sv | 25 ++
 rtl/seq_divider.sv | 166 ++++++++++++++++
 tb/tb_seq_divider.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding, default width, saturation
// constants and the decode encodings that route UDIV/SDIV to the divider.
package alu_pkg;

  localparam int DIV_DATA_WIDTH = 32;

  localparam logic [31:0] SATURATED_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SATURATED_MIN = 32'h8000_0000;

  localparam logic [3:0] ALU_UDIV = 4'hA;
  localparam logic [3:0] ALU_SDIV = 4'hB;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIXUP,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor, keep the difference and set the quotient bit when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH+1:0] w_shifted;
  logic [WIDTH+1:0] w_diff;
  logic             w_fits;

  // One extra bit of headroom so the sign of the trial difference is exact.
  assign w_shifted = {i_rem, i_quo[WIDTH-1]};
  assign w_diff    = w_shifted - {2'b00, i_divisor};
  assign w_fits    = ~w_diff[WIDTH+1];

  assign o_rem = w_fits ? w_diff[WIDTH:0] : w_shifted[WIDTH:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_fits};

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider (UDIV/SDIV) with valid/ready handshake and flush.
//   state | meaning
//   IDLE  | ready for a request
//   PREP  | take magnitudes, detect divide-by-zero / MIN over -1
//   ITER  | one quotient bit per cycle, down-counter tracks remaining bits
//   FIXUP | final quotient bit plus sign correction
//   DONE  | result held until out_ready
module seq_divider
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  is_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Quotient,
  output logic [DATA_WIDTH-1:0] Remainder,
  output logic                  div_by_zero,
  output logic                  sat_overflow
);

  localparam int N         = DATA_WIDTH;
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1);
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  div_state_e r_state;
  div_state_e w_next;

  logic [N-1:0]         r_a;
  logic [N-1:0]         r_b;
  logic                 r_signed;
  logic                 r_q_neg;
  logic                 r_r_neg;
  logic [N:0]           r_rem;
  logic [N-1:0]         r_quo;
  logic [N-1:0]         r_divisor;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [N-1:0]         r_quotient;
  logic [N-1:0]         r_remainder;
  logic                 r_dbz;
  logic                 r_ovf;

  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [N-1:0]         w_abs_a;
  logic [N-1:0]         w_abs_b;
  logic                 w_b_zero;
  logic                 w_ovf;
  logic [CNT_WIDTH-1:0] w_cnt_dec;
  logic [N:0]           w_step_rem;
  logic [N-1:0]         w_step_quo;

  assign w_a_neg   = r_signed & r_a[N-1];
  assign w_b_neg   = r_signed & r_b[N-1];
  assign w_abs_a   = w_a_neg ? -r_a : r_a;
  assign w_abs_b   = w_b_neg ? -r_b : r_b;
  assign w_b_zero  = (r_b == '0);
  assign w_ovf     = r_signed && (r_a == MIN_VAL) && (r_b == '1);
  assign w_cnt_dec = r_cnt - CNT_WIDTH'(1);

  div_step #(.WIDTH(N)) u_div_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) r_state <= IDLE;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = PREP;
      PREP:    w_next = (w_b_zero || w_ovf) ? DONE : ITER;
      ITER:    if (w_cnt_dec == CNT_WIDTH'(1)) w_next = FIXUP;
      FIXUP:   w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ITER covers N-1 bits; FIXUP consumes the last step so latency stays N+2.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_a         <= '0;
      r_b         <= '0;
      r_signed    <= 1'b0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_signed <= is_signed;
          end
        end
        PREP: begin
          r_q_neg <= w_a_neg ^ w_b_neg;
          r_r_neg <= w_a_neg;
          if (w_b_zero) begin
            r_quotient  <= '0;
            r_remainder <= r_a;
            r_dbz       <= 1'b1;
          end else if (w_ovf) begin
            r_quotient  <= MIN_VAL;
            r_remainder <= '0;
            r_ovf       <= 1'b1;
          end else begin
            r_rem     <= '0;
            r_quo     <= w_abs_a;
            r_divisor <= w_abs_b;
            r_cnt     <= CNT_WIDTH'(N);
          end
        end
        ITER: begin
          r_rem <= w_step_rem;
          r_quo <= w_step_quo;
          r_cnt <= w_cnt_dec;
        end
        FIXUP: begin
          r_rem       <= w_step_rem;
          r_quo       <= w_step_quo;
          r_cnt       <= w_cnt_dec;
          r_quotient  <= r_q_neg ? -w_step_quo : w_step_quo;
          r_remainder <= r_r_neg ? -w_step_rem[N-1:0] : w_step_rem[N-1:0];
        end
        DONE: begin
          if (out_ready) begin
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = (r_state == DONE);
  assign Quotient     = r_quotient;
  assign Remainder    = r_remainder;
  assign div_by_zero  = r_dbz;
  assign sat_overflow = r_ovf;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at 32 bits: expectations from a reference
// model are queued at issue time and popped when out_valid is seen.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, is_signed, out_ready;
  logic [31:0] a, b;
  logic        in_ready, out_valid, div_by_zero, sat_overflow;
  logic [31:0] Quotient, Remainder;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  seq_divider #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .is_signed    (is_signed),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .Quotient     (Quotient),
    .Remainder    (Remainder),
    .div_by_zero  (div_by_zero),
    .sat_overflow (sat_overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] da, input logic [31:0] db, input logic s);
    exp_t e;
    logic signed [31:0] sa, sd;
    sa = da;
    sd = db;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.lat = 34;
    if (db == 32'd0) begin
      e.q = 32'd0; e.r = da; e.dbz = 1'b1; e.lat = 2;
    end else if (s && da == 32'h8000_0000 && db == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'd0; e.ovf = 1'b1; e.lat = 2;
    end else if (s) begin
      e.q = sa / sd;
      e.r = sa % sd;
    end else begin
      e.q = da / db;
      e.r = da % db;
    end
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the PREP cycle.
  task automatic issue(input logic [31:0] da, input logic [31:0] db, input logic s);
    sb_q.push_back(model(da, db, s));
    a = da; b = db; is_signed = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result(output int lat, output bit timeout);
    lat = 1;
    timeout = 1'b0;
    while (!out_valid) begin
      if (lat >= 100) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_hs got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    checks++;
    if ({Quotient, Remainder, div_by_zero, sat_overflow} !== 66'd0) begin
      errors++;
      $display("FAIL reset_out got q=%h r=%h dbz=%b ovf=%b want all 0",
               Quotient, Remainder, div_by_zero, sat_overflow);
    end
  endtask

  task automatic test_arith();
    logic [31:0] ta[12];
    logic [31:0] tb[12];
    logic        ts[12];
    exp_t        e;
    int          lat;
    bit          to;
    ta[0] = 32'd100;       tb[0] = 32'd7;          ts[0] = 1'b0;
    ta[1] = 32'hFFFF_FF9C; tb[1] = 32'd7;          ts[1] = 1'b1;
    ta[2] = 32'd100;       tb[2] = 32'hFFFF_FFF9;  ts[2] = 1'b1;
    ta[3] = 32'h1234_5678; tb[3] = 32'd0;          ts[3] = 1'b0;
    ta[4] = 32'h1234_5678; tb[4] = 32'd0;          ts[4] = 1'b1;
    ta[5] = 32'h8000_0000; tb[5] = 32'hFFFF_FFFF;  ts[5] = 1'b1;
    ta[6] = 32'h8000_0000; tb[6] = 32'hFFFF_FFFF;  ts[6] = 1'b0;
    ta[7] = 32'hFFFF_FF9C; tb[7] = 32'hFFFF_FFF9;  ts[7] = 1'b1;
    ta[8] = 32'hFFFF_FFFF; tb[8] = 32'd1;          ts[8] = 1'b0;
    for (int i = 9; i < 12; i++) begin
      ta[i] = $urandom;
      tb[i] = $urandom_range(1, 32'h0FFF_FFFF) ^ (i[0] ? 32'h8000_0000 : 32'h0);
      ts[i] = i[0];
    end
    for (int i = 0; i < 12; i++) begin
      issue(ta[i], tb[i], ts[i]);
      wait_result(lat, to);
      e = sb_q.pop_front();
      checks++;
      if (to || lat != e.lat) begin
        errors++;
        $display("FAIL arith_lat[%0d] got %0d (timeout=%0b) want %0d", i, lat, to, e.lat);
      end
      checks++;
      if (Quotient !== e.q) begin
        errors++;
        $display("FAIL arith_q[%0d] got %h want %h", i, Quotient, e.q);
      end
      checks++;
      if (Remainder !== e.r) begin
        errors++;
        $display("FAIL arith_r[%0d] got %h want %h", i, Remainder, e.r);
      end
      checks++;
      if ({div_by_zero, sat_overflow} !== {e.dbz, e.ovf}) begin
        errors++;
        $display("FAIL arith_flags[%0d] got %b%b want %b%b", i,
                 div_by_zero, sat_overflow, e.dbz, e.ovf);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    bit   to;
    int   bad;
    out_ready = 1'b0;
    issue(32'h0000_CAFE, 32'd0, 1'b0);
    wait_result(lat, to);
    e = sb_q.pop_front();
    checks++;
    if (to || lat != e.lat || Remainder !== e.r || div_by_zero !== e.dbz) begin
      errors++;
      $display("FAIL bp_result got lat=%0d r=%h dbz=%b want lat=%0d r=%h dbz=%b",
               lat, Remainder, div_by_zero, e.lat, e.r, e.dbz);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || Quotient !== e.q ||
          Remainder !== e.r || div_by_zero !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, div_by_zero} !== 3'b100) begin
      errors++;
      $display("FAIL bp_release got in_ready=%b out_valid=%b dbz=%b want 1 0 0",
               in_ready, out_valid, div_by_zero);
    end
  endtask

  task automatic test_flush();
    exp_t e;
    int   lat;
    bit   to;
    int   seen;
    issue(32'd1000, 32'd3, 1'b0);
    void'(sb_q.pop_back());
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10 || Remainder !== 32'd0) begin
      errors++;
      $display("FAIL flush_state got in_ready=%b out_valid=%b r=%h want 1 0 0",
               in_ready, out_valid, Remainder);
    end
    a = 32'd50; b = 32'd5; is_signed = 1'b0; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_drop got in_ready=%b want 1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_no_valid got %0d valid cycles want 0", seen);
    end
    issue(32'd9, 32'd3, 1'b0);
    wait_result(lat, to);
    e = sb_q.pop_front();
    checks++;
    if (to || lat != e.lat || Quotient !== e.q || Remainder !== e.r) begin
      errors++;
      $display("FAIL flush_after got lat=%0d q=%h r=%h want lat=%0d q=%h r=%h",
               lat, Quotient, Remainder, e.lat, e.q, e.r);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    issue(32'd100, 32'd7, 1'b0);
    void'(sb_q.pop_back());
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({in_ready, out_valid, Quotient, Remainder, div_by_zero, sat_overflow} !== {2'b10, 66'd0}) begin
      errors++;
      $display("FAIL reset_mid got in_ready=%b out_valid=%b q=%h r=%h dbz=%b ovf=%b want 1 0 0 0 0 0",
               in_ready, out_valid, Quotient, Remainder, div_by_zero, sat_overflow);
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    int   lat;
    bit   to;
    issue(32'd1000, 32'd7, 1'b1);
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    wait_result(lat, to);
    e = sb_q.pop_front();
    checks++;
    if (to || lat != e.lat || Quotient !== e.q || Remainder !== e.r) begin
      errors++;
      $display("FAIL glitch got lat=%0d q=%h r=%h want lat=%0d q=%h r=%h",
               lat, Quotient, Remainder, e.lat, e.q, e.r);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; is_signed = 1'b0;
    out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_arith();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
